// File: rtl/pipe_ctrl.sv
// Valid/ready handshake controller for a STAGE-deep pipeline with bubble collapse.
// Optional back-pressure counter enabled by defining PIPE_CTRL_PERF_EN.
module pipe_ctrl #(
  parameter int STAGE = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic                         out_valid,
  input  logic                         out_ready,
  input  logic                         flush,
  output logic [STAGE-1:0]             stall,
  output logic [STAGE-1:0]             valid,
  output logic [$clog2(STAGE+1)-1:0]   occupancy,
  output logic [31:0]                  perf_stall_cnt
);

  localparam int OW = $clog2(STAGE+1);

  logic [STAGE-1:0] valid_r;
  logic [STAGE-1:0] valid_nxt_s;
  logic [STAGE-1:0] load_s;
  logic             run_full_s;
  logic [OW-1:0]    count_s;

  // Load ripple from the output end: a stage holds only if it and every stage after it is full and blocked
  always_comb begin
    load_s     = '0;
    run_full_s = 1'b1;
    for (int i = STAGE-1; i >= 0; i--) begin
      run_full_s = run_full_s & valid_r[i];
      load_s[i]  = out_ready | ~run_full_s;
    end
  end

  // Next valid vector when not flushing
  always_comb begin
    valid_nxt_s = valid_r;
    if (load_s[0]) begin
      valid_nxt_s[0] = in_valid;
    end else begin
      valid_nxt_s[0] = valid_r[0];
    end
    for (int i = 1; i < STAGE; i++) begin
      if (load_s[i]) begin
        valid_nxt_s[i] = valid_r[i-1];
      end else begin
        valid_nxt_s[i] = valid_r[i];
      end
    end
  end

  // Population count of the valid bits
  always_comb begin
    count_s = '0;
    for (int i = 0; i < STAGE; i++) begin
      count_s = count_s + OW'(valid_r[i]);
    end
  end

  // Stage valid register; flush discards everything loaded this edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_r <= '0;
    end else if (flush) begin
      valid_r <= '0;
    end else begin
      valid_r <= valid_nxt_s;
    end
  end

  assign stall     = ~load_s;
  assign in_ready  = load_s[0] & ~flush;
  assign out_valid = valid_r[STAGE-1];
  assign valid     = valid_r;
  assign occupancy = count_s;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_cnt_r;

  // Saturating back-pressure counter; survives flush, cleared only by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_cnt_r <= 32'd0;
    end else if (valid_r[STAGE-1] && !out_ready && (perf_cnt_r != 32'hFFFF_FFFF)) begin
      perf_cnt_r <= perf_cnt_r + 32'd1;
    end else begin
      perf_cnt_r <= perf_cnt_r;
    end
  end

  assign perf_stall_cnt = perf_cnt_r;
`else
  assign perf_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: slot-level reference model plus tagged shadow datapath.
module tb_pipe_ctrl;
  localparam int STAGE = 4;
  localparam int OW = $clog2(STAGE+1);
`ifdef PIPE_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, in_valid, in_ready, out_valid, out_ready, flush;
  logic [STAGE-1:0] stall, valid;
  logic [OW-1:0] occupancy;
  logic [31:0] perf_stall_cnt;

  pipe_ctrl #(.STAGE(STAGE)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .flush(flush),
    .stall(stall), .valid(valid), .occupancy(occupancy),
    .perf_stall_cnt(perf_stall_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int n_out = 0;
  int next_tag = 1;
  logic [15:0] in_data;
  logic [15:0] dp [STAGE];
  int exp_q [$];
  logic [STAGE-1:0] m_v;
  logic [31:0] m_pc;

  // Shadow datapath driven by the DUT's stall enables
  always @(posedge clk) begin
    if (!stall[0]) dp[0] <= in_data;
    for (int i = 1; i < STAGE; i++)
      if (!stall[i]) dp[i] <= dp[i-1];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every output transfer must carry the oldest outstanding tag
  initial begin
    int t;
    forever begin
      @(negedge clk);
      if (!reset && out_valid === 1'b1 && out_ready === 1'b1) begin
        n_out++;
        if (exp_q.size() == 0) begin
          chk("unexpected_output", {16'd0, dp[STAGE-1]}, 32'hFFFF_FFFF);
        end else begin
          t = exp_q.pop_front();
          chk("out_tag", {16'd0, dp[STAGE-1]}, t[31:0] & 32'h0000_FFFF);
        end
      end
    end
  end

  // One clock of stimulus; model holds a stage iff it lies in the full run at the tail and output is blocked
  task automatic cycle(input bit iv, input bit ordy, input bit fl);
    logic [STAGE-1:0] hold, nv;
    bit ir;
    int run;
    in_valid = iv; out_ready = ordy; flush = fl; in_data = next_tag[15:0];
    #3;
    run = 0;
    while (run < STAGE && m_v[STAGE-1-run]) run++;
    hold = '0;
    if (!ordy) for (int i = STAGE - run; i < STAGE; i++) hold[i] = 1'b1;
    ir = !hold[0] && !fl;
    chk("valid", valid, m_v);
    chk("occupancy", occupancy, $countones(m_v));
    chk("stall", stall, hold);
    chk("in_ready", in_ready, ir);
    chk("out_valid", out_valid, m_v[STAGE-1]);
    chk("perf_stall_cnt", perf_stall_cnt, m_pc);
    for (int i = 0; i < STAGE; i++)
      nv[i] = hold[i] ? m_v[i] : (i == 0 ? iv : m_v[(i == 0) ? 0 : i-1]);
    if (fl) nv = '0;
    @(posedge clk);
    #1;
    if (PERF && m_v[STAGE-1] && !ordy && m_pc != 32'hFFFF_FFFF) m_pc = m_pc + 32'd1;
    m_v = nv;
    if (fl) exp_q.delete();
    if (ir && iv) begin
      exp_q.push_back(next_tag);
      next_tag++;
    end
  endtask

  initial begin
    int saved;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; in_data = 16'd0;
    m_v = '0; m_pc = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", valid, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_stall", stall, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_perf", perf_stall_cnt, 0);
    reset = 1'b0;

    // Streaming: full throughput
    repeat (8) cycle(1, 1, 0);
    chk("stream_occ", occupancy, 4);
    chk("stream_in_ready", in_ready, 1);

    // Back-pressure on a full pipe
    repeat (3) cycle(1, 0, 0);
    chk("full_stall", stall, 4'b1111);
    chk("full_in_ready", in_ready, 0);
    chk("full_occ", occupancy, 4);

    // Flush with a simultaneous output transfer
    saved = n_out;
    cycle(0, 1, 1);
    chk("flush_valid", valid, 0);
    chk("flush_occ", occupancy, 0);
    chk("flush_xfer", n_out, saved + 1);
    flush = 1'b0;
    #1;
    chk("flush_in_ready", in_ready, 1);

    // Bubble collapse of a single item
    cycle(1, 0, 0);
    repeat (3) cycle(0, 0, 0);
    chk("bubble_valid", valid, 4'b1000);
    chk("bubble_stall", stall, 4'b1000);
    chk("bubble_in_ready", in_ready, 1);

    // Alternating back-pressure with tagged data
    for (int k = 0; k < 40; k++) cycle(1, k[0], 0);

    // Asynchronous reset between edges at occupancy 3
    cycle(0, 0, 1);
    repeat (3) cycle(1, 0, 0);
    chk("pre_rst_occ", occupancy, 3);
    in_valid = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk("async_valid", valid, 0);
    chk("async_occ", occupancy, 0);
    chk("async_out_valid", out_valid, 0);
    m_v = '0; m_pc = 32'd0; exp_q.delete();
    #1 reset = 1'b0;
    @(posedge clk);
    #1;

    // Randomized traffic
    for (int k = 0; k < 500; k++)
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 31) == 0);

    // Drain and confirm nothing was lost
    repeat (STAGE + 2) cycle(0, 1, 0);
    chk("drain_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Handshake controller for a linear chain of STAGE pipeline flip-flop stages. It tracks a valid bit per stage and converts an upstream valid/ready handshake and a downstream valid/ready handshake into per-stage `stall` enables that drive the datapath registers. Empty stages (bubbles) are collapsed, so a downstream back-pressure event only freezes stages that hold valid data. The block sits beside every multi-stage datapath in the design; the datapath registers carry payload and this block carries control.

## Interface
- `STAGE`, 4, number of pipeline stages controlled; legal range 1..32.
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-high; clears all stage valid bits.
- `in_valid`  in  1  upstream presents data on this cycle.
- `in_ready`  out  1  stage 0 accepts data at this edge.
- `out_valid`  out  1  last stage holds valid data.
- `out_ready`  in  1  downstream consumes last-stage data at this edge.
- `flush`  in  1  invalidate every stage at the next edge.
- `stall`  out  STAGE  `stall[i]`=1 holds datapath stage i; 0 loads it from stage i-1 (stage 0 loads from upstream).
- `valid`  out  STAGE  per-stage valid bits (registered).
- `occupancy`  out  $clog2(STAGE+1)  number of set bits in `valid`.
- `perf_stall_cnt`  out  32  back-pressure cycle counter (see Configuration).

## Operation
- State: `valid[STAGE-1:0]` register only; all other outputs combinational from it and the inputs.
- Load terms, computed from the output end:
  - `load[STAGE-1] = !valid[STAGE-1] | out_ready`
  - `load[i] = !valid[i] | load[i+1]`
- `stall[i] = !load[i]`; `in_ready = load[0] & !flush`; `out_valid = valid[STAGE-1]`.
- Next state, when `flush`=0:
  - `valid[0] <= load[0] ? in_valid : valid[0]`
  - `valid[i] <= load[i] ? valid[i-1] : valid[i]`
- `flush`=1: every `valid` bit is 0 at the next edge, regardless of `in_valid` or `out_ready`.
  - `stall` still follows the load rule; the loaded data is discarded because it is marked invalid.
  - A simultaneous `out_valid & out_ready` transfer in the flush cycle still completes.
- Bubble collapse: a valid stage advances into an empty downstream stage even while `out_ready`=0.
- Ordering: no reordering and no duplication. Each accepted item leaves exactly once, unless it is flushed.
- STAGE=1: `load[0] = !valid[0] | out_ready`, which degenerates to a one-entry skid-free register slice.

## Timing
- Reset values:
  - `valid` = 0, `occupancy` = 0, `out_valid` = 0, `perf_stall_cnt` = 0.
  - `stall` = 0 (combinational from the cleared state).
  - `in_ready` = !flush.
- Reset asserted mid-operation clears `valid` immediately (asynchronous); in-flight data is lost.
- Latency: an item accepted at edge N is presented on `out_valid` after edge N+STAGE-1, provided there is no back-pressure.
- Throughput: one item per cycle while `out_ready`=1.
- Full: all `valid`=1 and `out_ready`=0 gives all `stall`=1 and `in_ready`=0.
- Full with `out_ready`=1: all `stall`=0 and `in_ready`=1, so simultaneous accept and release keeps occupancy at STAGE.
- Combinational path: `out_ready` to `in_ready` and `stall` is a ripple chain of STAGE stages.

## Configuration
- `PIPE_CTRL_PERF_EN` defined: `perf_stall_cnt` increments each cycle with `out_valid & !out_ready`.
  - The counter saturates at 0xFFFF_FFFF.
  - It is cleared by `reset` only; `flush` does not clear it.
- Not defined: `perf_stall_cnt` is tied to 0 and no counter flops are generated. Port list is unchanged.

## Test plan
- After reset, STAGE=4, `in_valid`=1, `out_ready`=1 constantly -> `in_ready`=1 every cycle; first `out_valid`=1 after edge 3; `occupancy` reaches 4 and stays there.
- Fill 4 items, then `out_ready`=0 -> `stall`=4'b1111, `in_ready`=0, `occupancy`=4; `perf_stall_cnt` +1 per cycle (with `PIPE_CTRL_PERF_EN`).
- Single item in stage 0, `out_ready`=0 -> item reaches stage 3 after 3 edges (bubble collapse); `valid`=4'b1000, then `stall`=4'b1000, `in_ready`=1.
- Full pipe, `flush`=1 for one cycle with `out_ready`=1 -> one output transfer completes; next cycle `valid`=0, `occupancy`=0, `in_ready`=1.
- Alternating `out_ready` 1/0 with `in_valid`=1 and tagged data -> output tag sequence strictly increasing by 1, no gaps or repeats.
- `reset` asserted between edges while `occupancy`=3 -> `valid`, `occupancy` and `out_valid` go to 0 before the next edge.
